// File: rtl/wm_panel_input.sv
// Washing-machine front-panel conditioner: synchronizes and debounces keys and switches,
// derives press / long-hold events and runs the IDLE/RUN/PAUSED request state machine.
module wm_panel_input #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_pause_n,
  input  logic       key_mode_n,
  input  logic       sw_cover,
  input  logic       sw_water,
  output logic       start,
  output logic       pause,
  output logic [1:0] mode,
  output logic       cover_closed,
  output logic       water_connected,
  output logic       interlock_err
);

  localparam int N_IN = 5;
  localparam int N_KEY = 3;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);
  // Bit order: start, pause, mode keys (active-low), then cover, water switches.
  localparam logic [N_IN-1:0] IDLE_LEVEL = 5'b00111;
  localparam logic [DW-1:0]   DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0]   LONG_LAST  = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0]   LONG_MAX   = LW'(LONG_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  logic [N_IN-1:0]  raw;
  logic [N_IN-1:0]  debounced;
  logic [N_KEY-1:0] key_sync;

  assign raw = {sw_water, sw_cover, key_mode_n, key_pause_n, key_start_n};

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_cond
      logic          sync1_reg;
      logic          sync2_reg;
      logic          stable_reg;
      logic [DW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_reg  <= IDLE_LEVEL[gi];
          sync2_reg  <= IDLE_LEVEL[gi];
          stable_reg <= IDLE_LEVEL[gi];
          cnt_reg    <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + DW'(1);
          end
        end
      end

      assign debounced[gi] = stable_reg;

      if (gi < N_KEY) begin : g_key
        assign key_sync[gi] = sync2_reg;
      end
    end
  endgenerate

  logic [N_KEY-1:0] key_q_reg;
  logic [1:0]       settle_reg;
  logic [N_KEY-1:0] armed_reg;
  logic [LW-1:0]    long_cnt_reg;
  logic [N_KEY-1:0] press;
  logic             long_evt;
  logic             ok;

  // A key only arms once the synchronizer has shown it released after reset,
  // so a key held through reset must be released and pressed again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q_reg    <= '1;
      settle_reg   <= '0;
      armed_reg    <= '0;
      long_cnt_reg <= '0;
    end else begin
      key_q_reg  <= debounced[N_KEY-1:0];
      settle_reg <= {settle_reg[0], 1'b1};
      if (settle_reg[1]) begin
        armed_reg <= armed_reg | key_sync;
      end
      if (key_q_reg[0]) begin
        long_cnt_reg <= '0;
      end else if (long_cnt_reg != LONG_MAX) begin
        long_cnt_reg <= long_cnt_reg + LW'(1);
      end
    end
  end

  assign press    = armed_reg & key_q_reg & ~debounced[N_KEY-1:0];
  assign long_evt = !key_q_reg[0] && (long_cnt_reg == LONG_LAST);
  assign ok       = debounced[3] && debounced[4];

  state_t     state_reg;
  logic       start_reg;
  logic       pause_reg;
  logic [1:0] mode_reg;
  logic       err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      start_reg <= 1'b0;
      pause_reg <= 1'b0;
      mode_reg  <= 2'd0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (press[0]) begin
            if (ok) begin
              state_reg <= RUN;
              start_reg <= 1'b1;
              pause_reg <= 1'b0;
            end else begin
              err_reg <= 1'b1;
            end
          end
          if (press[2]) begin
            mode_reg <= (mode_reg == 2'd2) ? 2'd0 : mode_reg + 2'd1;
          end
        end
        RUN: begin
          if (long_evt) begin
            state_reg <= IDLE;
            start_reg <= 1'b0;
            pause_reg <= 1'b0;
          end else if (press[1] || !ok) begin
            state_reg <= PAUSED;
            start_reg <= 1'b0;
            pause_reg <= 1'b1;
          end
        end
        PAUSED: begin
          if (long_evt) begin
            state_reg <= IDLE;
            start_reg <= 1'b0;
            pause_reg <= 1'b0;
          end else if (press[1] || press[0]) begin
            if (ok) begin
              state_reg <= RUN;
              start_reg <= 1'b1;
              pause_reg <= 1'b0;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          start_reg <= 1'b0;
          pause_reg <= 1'b0;
        end
      endcase
    end
  end

  assign start           = start_reg;
  assign pause           = pause_reg;
  assign mode            = mode_reg;
  assign interlock_err   = err_reg;
  assign cover_closed    = debounced[3];
  assign water_connected = debounced[4];

endmodule

// File: tb/tb_wm_panel_input.sv
// Directed scoreboard bench for wm_panel_input: expected output changes (value and cycle)
// are queued by the stimulus and matched by a monitor whenever the outputs change.
module tb_wm_panel_input;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_start_n = 1'b1;
  logic       key_pause_n = 1'b1;
  logic       key_mode_n = 1'b1;
  logic       sw_cover = 1'b1;
  logic       sw_water = 1'b1;
  logic       start;
  logic       pause;
  logic [1:0] mode;
  logic       cover_closed;
  logic       water_connected;
  logic       interlock_err;

  wm_panel_input #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_start_n(key_start_n),
    .key_pause_n(key_pause_n),
    .key_mode_n(key_mode_n),
    .sw_cover(sw_cover),
    .sw_water(sw_water),
    .start(start),
    .pause(pause),
    .mode(mode),
    .cover_closed(cover_closed),
    .water_connected(water_connected),
    .interlock_err(interlock_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [6:0] v;
    string      name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails = 0;
  logic [6:0] last_vec = 7'b0;

  // Output vector: {start, pause, mode[1:0], cover_closed, water_connected, interlock_err}
  function automatic logic [6:0] cur_vec();
    return {start, pause, mode, cover_closed, water_connected, interlock_err};
  endfunction

  always @(negedge clk) begin
    logic [6:0] cur;
    exp_t e;
    cur = cur_vec();
    if (cur !== last_vec) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change cyc=%0d got=%b (no change expected)", cyc, cur);
      end else begin
        e = sb.pop_front();
        if (e.t != cyc || e.v !== cur) begin
          fails++;
          $display("FAIL %s got=%b at cyc=%0d, expected=%b at cyc=%0d", e.name, cur, cyc, e.v, e.t);
        end else begin
          $display("ok   %s vec=%b cyc=%0d", e.name, cur, cyc);
        end
      end
      last_vec = cur;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int t, input string name, input logic s, input logic p,
                           input logic [1:0] m, input logic c, input logic w, input logic e);
    exp_t x;
    x.t = t;
    x.v = {s, p, m, c, w, e};
    x.name = name;
    sb.push_back(x);
  endtask

  task automatic check_now(input string name, input logic [6:0] want);
    logic [6:0] cur;
    cur = cur_vec();
    checks++;
    if (cur !== want) begin
      fails++;
      $display("FAIL %s got=%b expected=%b", name, cur, want);
    end else begin
      $display("ok   %s vec=%b", name, cur);
    end
  endtask

  task automatic press_key(input int which, input int len);
    case (which)
      0: key_start_n = 1'b0;
      1: key_pause_n = 1'b0;
      default: key_mode_n = 1'b0;
    endcase
    tick(len);
    case (which)
      0: key_start_n = 1'b1;
      1: key_pause_n = 1'b1;
      default: key_mode_n = 1'b1;
    endcase
  endtask

  logic [1:0] mode_seq [4] = '{2'd1, 2'd2, 2'd0, 2'd1};

  initial begin
    tick(3);
    check_now("reset_state", 7'b0);
    expect_at(cyc + 6, "switches_after_reset", 0, 0, 2'd0, 1, 1, 0);
    reset = 1'b1;
    tick(12);

    // 3-cycle glitch must be rejected
    key_start_n = 1'b0;
    tick(3);
    key_start_n = 1'b1;
    tick(12);

    expect_at(cyc + 7, "start_press_run", 1, 0, 2'd0, 1, 1, 0);
    press_key(0, 10);
    tick(12);

    expect_at(cyc + 7, "pause_press", 0, 1, 2'd0, 1, 1, 0);
    press_key(1, 6);
    tick(12);
    expect_at(cyc + 7, "resume_by_start", 1, 0, 2'd0, 1, 1, 0);
    press_key(0, 6);
    tick(12);

    // cover open for 10 cycles, pause pressed while open
    expect_at(cyc + 6, "cover_open", 1, 0, 2'd0, 0, 1, 0);
    expect_at(cyc + 7, "interlock_drop_pause", 0, 1, 2'd0, 0, 1, 0);
    expect_at(cyc + 9, "resume_rejected_err", 0, 1, 2'd0, 0, 1, 1);
    expect_at(cyc + 10, "err_one_cycle", 0, 1, 2'd0, 0, 1, 0);
    expect_at(cyc + 16, "cover_closed_again", 0, 1, 2'd0, 1, 1, 0);
    sw_cover = 1'b0;
    tick(2);
    press_key(1, 6);
    tick(2);
    sw_cover = 1'b1;
    tick(14);

    expect_at(cyc + 7, "resume_after_cover", 1, 0, 2'd0, 1, 1, 0);
    press_key(0, 6);
    tick(12);

    expect_at(cyc + 27, "long_hold_idle", 0, 0, 2'd0, 1, 1, 0);
    press_key(0, 30);
    tick(15);

    for (int i = 0; i < 4; i++) begin
      expect_at(cyc + 7, "mode_step", 0, 0, mode_seq[i], 1, 1, 0);
      press_key(2, 6);
      tick(12);
    end

    expect_at(cyc + 7, "run_mode_kept", 1, 0, 2'd1, 1, 1, 0);
    press_key(0, 6);
    tick(12);
    press_key(2, 6);
    tick(12);

    // async reset mid-RUN with start held through it
    key_start_n = 1'b0;
    tick(8);
    @(posedge clk);
    #2;
    expect_at(cyc, "async_reset_outputs", 0, 0, 2'd0, 0, 0, 0);
    reset = 1'b0;
    #1;
    check_now("reset_immediate", 7'b0);
    tick(2);
    reset = 1'b1;
    expect_at(cyc + 6, "switches_after_rereset", 0, 0, 2'd0, 1, 1, 0);
    tick(30);
    key_start_n = 1'b1;
    tick(12);
    expect_at(cyc + 7, "fresh_press_run", 1, 0, 2'd0, 1, 1, 0);
    press_key(0, 6);
    tick(12);

    // water interlock
    expect_at(cyc + 6, "water_drop", 1, 0, 2'd0, 1, 0, 0);
    expect_at(cyc + 7, "water_drop_pause", 0, 1, 2'd0, 1, 0, 0);
    sw_water = 1'b0;
    tick(12);
    expect_at(cyc + 7, "paused_start_err", 0, 1, 2'd0, 1, 0, 1);
    expect_at(cyc + 8, "paused_err_clear", 0, 1, 2'd0, 1, 0, 0);
    expect_at(cyc + 27, "paused_long_idle", 0, 0, 2'd0, 1, 0, 0);
    press_key(0, 30);
    tick(15);
    expect_at(cyc + 7, "idle_start_err", 0, 0, 2'd0, 1, 0, 1);
    expect_at(cyc + 8, "idle_err_clear", 0, 0, 2'd0, 1, 0, 0);
    press_key(0, 6);
    tick(12);
    expect_at(cyc + 6, "water_back", 0, 0, 2'd0, 1, 1, 0);
    sw_water = 1'b1;
    tick(12);
    expect_at(cyc + 7, "start_with_water", 1, 0, 2'd0, 1, 1, 0);
    press_key(0, 6);
    tick(12);

    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      fails++;
      $display("FAIL %s never seen, expected=%b at cyc=%0d", x.name, x.v, x.t);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
